// File: rtl/cust_stim_pkg.sv
// rtl/cust_stim_pkg.sv - shared widths, channel state type and compare helper
package cust_stim_pkg;

    localparam int SAMPLE_W = 16;
    localparam int CNT_W    = 16;
    localparam logic RST_BELOW = 1'b1;

    // Per-channel tracking word: last-sample-below flag plus refractory countdown
    typedef struct packed {
        logic             below;
        logic [CNT_W-1:0] rcnt;
    } chan_state_t;

    // Reset word: "below" set so the first crossing needs a prior above-threshold sample
    localparam chan_state_t CHAN_STATE_RST = '{below: RST_BELOW, rcnt: '0};

    // Two's complement a <= b, shared by the threshold stages
    function automatic logic signed_le(input logic signed [SAMPLE_W-1:0] a,
                                       input logic signed [SAMPLE_W-1:0] b);
        return a <= b;
    endfunction

endpackage

// File: rtl/cust_chan_state_ram.sv
// rtl/cust_chan_state_ram.sv - per-channel state array, comb read, clocked write
module cust_chan_state_ram
    import cust_stim_pkg::*;
#(
    parameter int CHANNELS     = 1,
    parameter int CHANNELS_PW2 = 7
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [CHANNELS_PW2-1:0] rd_addr,
    output chan_state_t             rd_data,
    input  logic                    wr_en,
    input  logic [CHANNELS_PW2-1:0] wr_addr,
    input  chan_state_t             wr_data
);

    chan_state_t mem [CHANNELS];

    // Read mux by address compare; out-of-range addresses return the reset word
    always_comb begin
        rd_data = CHAN_STATE_RST;
        for (int i = 0; i < CHANNELS; i++) begin
            if (rd_addr == CHANNELS_PW2'(i)) begin
                rd_data = mem[i];
            end
        end
    end

    // Async clear of every entry; write only the addressed entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                mem[i] <= CHAN_STATE_RST;
            end
        end else if (wr_en) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_addr == CHANNELS_PW2'(i)) begin
                    mem[i] <= wr_data;
                end
            end
        end
    end

endmodule

// File: rtl/cust_spike_detector.sv
// rtl/cust_spike_detector.sv - per-channel negative threshold crossing detector with refractory
module cust_spike_detector
    import cust_stim_pkg::*;
#(
    parameter int CHANNELS     = 1,
    parameter int CHANNELS_PW2 = 7
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SAMPLE_W-1:0]     chan_in_sample,
    input  logic [CHANNELS_PW2-1:0] chan_in_num,
    input  logic                    chan_in_valid,
    output logic                    chan_in_read,
    input  logic [SAMPLE_W-1:0]     threshold,
    input  logic [CNT_W-1:0]        refractory,
    input  logic                    enable,
    output logic [CHANNELS_PW2-1:0] spike_num,
    output logic                    spike_valid,
    input  logic                    spike_read,
    output logic [CNT_W-1:0]        spike_count
);

    localparam logic [CHANNELS_PW2:0] NUM_CH = (CHANNELS_PW2 + 1)'(CHANNELS);

    chan_state_t cur_state;
    chan_state_t nxt_state;
    logic        accept;
    logic        in_range;
    logic        s_le;
    logic        fire;

    cust_chan_state_ram #(
        .CHANNELS     (CHANNELS),
        .CHANNELS_PW2 (CHANNELS_PW2)
    ) u_state (
        .clk     (clk),
        .reset   (reset),
        .rd_addr (chan_in_num),
        .rd_data (cur_state),
        .wr_en   (accept && in_range),
        .wr_addr (chan_in_num),
        .wr_data (nxt_state)
    );

    // Handshake, crossing detection and next per-channel state
    always_comb begin
        chan_in_read    = !spike_valid || spike_read;
        accept          = chan_in_valid && chan_in_read;
        in_range        = {1'b0, chan_in_num} < NUM_CH;
        s_le            = signed_le(chan_in_sample, threshold);
        fire            = accept && in_range && s_le && !cur_state.below
                          && (cur_state.rcnt == '0) && enable;
        nxt_state.below = s_le;
        if (fire) begin
            nxt_state.rcnt = refractory;
        end else if (cur_state.rcnt != '0) begin
            nxt_state.rcnt = cur_state.rcnt - CNT_W'(1);
        end else begin
            nxt_state.rcnt = '0;
        end
    end

    // Event register: a new fire wins over a same-edge read so nothing is dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spike_valid <= 1'b0;
            spike_num   <= '0;
        end else if (fire) begin
            spike_valid <= 1'b1;
            spike_num   <= chan_in_num;
        end else if (spike_valid && spike_read) begin
            spike_valid <= 1'b0;
        end
    end

    // Saturating count of emitted events
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spike_count <= '0;
        end else if (fire && (spike_count != '1)) begin
            spike_count <= spike_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_cust_spike_detector.sv
// tb/tb_cust_spike_detector.sv - scoreboard bench for cust_spike_detector
module tb_cust_spike_detector;

    localparam int CH = 4;
    localparam int PW = 7;

    logic          clk = 1'b0;
    logic          reset;
    logic [15:0]   chan_in_sample;
    logic [PW-1:0] chan_in_num;
    logic          chan_in_valid;
    logic          chan_in_read;
    logic [15:0]   threshold;
    logic [15:0]   refractory;
    logic          enable;
    logic [PW-1:0] spike_num;
    logic          spike_valid;
    logic          spike_read;
    logic [15:0]   spike_count;

    int vectors     = 0;
    int miscompares = 0;
    int exp_q[$];
    int mon_exp;

    cust_spike_detector #(
        .CHANNELS     (CH),
        .CHANNELS_PW2 (PW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .chan_in_sample (chan_in_sample),
        .chan_in_num    (chan_in_num),
        .chan_in_valid  (chan_in_valid),
        .chan_in_read   (chan_in_read),
        .threshold      (threshold),
        .refractory     (refractory),
        .enable         (enable),
        .spike_num      (spike_num),
        .spike_valid    (spike_valid),
        .spike_read     (spike_read),
        .spike_count    (spike_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every event handed downstream must match the oldest expected one
    always @(negedge clk) begin
        if (!reset && spike_valid && spike_read) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_event: got spike_num %0d expected none at %0t", spike_num, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                check("spike_num", int'(spike_num), mon_exp);
            end
        end
    end

    // Present one sample (called at posedge+1), wait for acceptance, check event presence
    task automatic send(input int s, input int c, input bit fire);
        int n;
        n = 0;
        chan_in_sample = 16'(s);
        chan_in_num    = PW'(c);
        chan_in_valid  = 1'b1;
        while (!chan_in_read && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!chan_in_read) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: got chan_in_read 0 expected 1 at %0t", $time);
        end
        if (fire) exp_q.push_back(c);
        @(posedge clk);
        #1;
        chan_in_valid = 1'b0;
        check("spike_valid", int'(spike_valid), int'(fire));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset          = 1'b1;
        chan_in_sample = '0;
        chan_in_num    = '0;
        chan_in_valid  = 1'b0;
        threshold      = 16'(-200);
        refractory     = 16'd0;
        enable         = 1'b1;
        spike_read     = 1'b1;
        @(posedge clk);
        #1;
        check("rst_valid", int'(spike_valid), 0);
        check("rst_num", int'(spike_num), 0);
        check("rst_count", int'(spike_count), 0);
        check("rst_read", int'(chan_in_read), 1);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // First low sample after reset does not fire; then fresh crossings only
        send(-300, 0, 0);
        send(0,    0, 0);
        send(-250, 0, 1);
        send(-260, 0, 0);
        send(0,    0, 0);
        send(-300, 0, 1);
        check("count_t2", int'(spike_count), 2);

        // Refractory of 3 samples: lows 1, 3 and 5 fire
        refractory = 16'd3;
        for (int i = 0; i < 12; i++) begin
            send((i % 2 == 1) ? -300 : 0, 0, (i == 1) || (i == 5) || (i == 9));
        end
        // Sustained low level does not re-fire after expiry
        send(0, 0, 0);
        send(-300, 0, 1);
        for (int i = 0; i < 5; i++) send(-300, 0, 0);
        check("count_t3", int'(spike_count), 6);

        // Interleaved channels; ch2 refractory counts only ch2 samples
        refractory = 16'd2;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < CH; c++) begin
                send((c == 2 && r % 2 == 1) ? -300 : 0, c, (c == 2) && (r == 1 || r == 5));
            end
            if (r == 2) send(-300, 5, 0);
        end
        check("count_t5", int'(spike_count), 8);

        // Disabled crossing neither fires nor loads the counter
        refractory = 16'd3;
        enable = 1'b0;
        send(-300, 0, 0);
        enable = 1'b1;
        send(0, 0, 0);
        send(-300, 0, 1);

        // Most negative threshold never fires
        threshold = 16'h8000;
        send(0, 1, 0);
        send(-32767, 1, 0);
        send(0, 1, 0);
        threshold  = 16'(-200);
        refractory = 16'd0;
        check("count_t6", int'(spike_count), 9);

        // Backpressure: pending event stalls input, then back-to-back replacement
        spike_read = 1'b0;
        send(-300, 3, 1);
        check("bp_read", int'(chan_in_read), 0);
        chan_in_sample = 16'(-300);
        chan_in_num    = PW'(1);
        chan_in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("bp_read_hold", int'(chan_in_read), 0);
            check("bp_num_stable", int'(spike_num), 3);
            check("bp_valid_hold", int'(spike_valid), 1);
        end
        exp_q.push_back(1);
        spike_read = 1'b1;
        @(posedge clk);
        #1;
        chan_in_valid = 1'b0;
        check("b2b_valid", int'(spike_valid), 1);
        check("b2b_num", int'(spike_num), 1);
        @(posedge clk);
        #1;
        check("b2b_drain", int'(spike_valid), 0);
        check("count_t4", int'(spike_count), 11);

        // Reset with an event pending: event lost, outputs cleared immediately
        send(0, 3, 0);
        spike_read = 1'b0;
        send(-300, 3, 1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", int'(spike_valid), 0);
        check("mid_rst_count", int'(spike_count), 0);
        check("mid_rst_read", int'(chan_in_read), 1);
        check("mid_rst_num", int'(spike_num), 0);
        exp_q.delete();
        reset = 1'b0;
        @(posedge clk);
        #1;
        spike_read = 1'b1;
        send(-300, 0, 0);
        check("post_rst_count", int'(spike_count), 0);

        // Saturation of the event counter
        force dut.spike_count = 16'hFFFE;
        #1;
        release dut.spike_count;
        send(0, 0, 0);
        send(-300, 0, 1);
        check("sat_count1", int'(spike_count), 16'hFFFF);
        send(0, 0, 0);
        send(-300, 0, 1);
        check("sat_count2", int'(spike_count), 16'hFFFF);

        @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
